// File: rtl/instr_sequencer.sv
// Multi-cycle FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK control sequencer for the LEGv8 core.
// Optional single-step start input enabled by defining INSTR_SEQUENCER_SINGLE_STEP_EN.
module instr_sequencer #(
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run,
`ifdef INSTR_SEQUENCER_SINGLE_STEP_EN
  input  logic             step,
`endif
  input  logic             fetch_ack,
  input  logic             mem_read,
  input  logic             mem_write,
  input  logic             reg_write,
  input  logic             mem_ack,
  output logic             fetch_req,
  output logic             ir_load,
  output logic             reg_read_en,
  output logic             alu_en,
  output logic             mem_req,
  output logic             wb_en,
  output logic             pc_update,
  output logic             busy,
  output logic             fault,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] retired
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_FETCH     = 3'd1,
    S_DECODE    = 3'd2,
    S_EXECUTE   = 3'd3,
    S_MEMORY    = 3'd4,
    S_WRITEBACK = 3'd5,
    S_FAULT     = 3'd6
  } state_t;

  // Counter only needs to reach MEM_TIMEOUT-1.
  localparam int TMO_W = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

  state_t           r_state;
  state_t           w_next;
  logic             r_mem_read;
  logic             r_mem_write;
  logic             r_reg_write;
  logic [TMO_W-1:0] r_tmo_cnt;
  logic [CNT_W-1:0] r_retired;
  logic             w_start;
  logic             w_tmo_hit;

`ifdef INSTR_SEQUENCER_SINGLE_STEP_EN
  assign w_start = run | step;
`else
  assign w_start = run;
`endif

  assign w_tmo_hit = (MEM_TIMEOUT != 0) && (r_tmo_cnt == TMO_LAST);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_mem_read  <= 1'b0;
      r_mem_write <= 1'b0;
      r_reg_write <= 1'b0;
      r_tmo_cnt   <= '0;
      r_retired   <= '0;
    end else begin
      if (r_state == S_DECODE) begin
        r_mem_read  <= mem_read;
        r_mem_write <= mem_write;
        r_reg_write <= reg_write;
      end
      // Held at zero outside MEMORY, so every MEMORY visit starts counting from zero.
      if (r_state == S_MEMORY) r_tmo_cnt <= r_tmo_cnt + 1'b1;
      else                     r_tmo_cnt <= '0;
      if (r_state == S_WRITEBACK) r_retired <= r_retired + 1'b1;
    end
  end

  // NOTE: default assignment first so no path through the case leaves a latch.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:      if (w_start) w_next = S_FETCH;
      S_FETCH:     if (fetch_ack) w_next = S_DECODE;
      S_DECODE:    w_next = S_EXECUTE;
      S_EXECUTE:   w_next = (r_mem_read | r_mem_write) ? S_MEMORY : S_WRITEBACK;
      S_MEMORY: begin
        if (mem_ack)        w_next = S_WRITEBACK;
        else if (w_tmo_hit) w_next = S_FAULT;
      end
      S_WRITEBACK: w_next = run ? S_FETCH : S_IDLE;
      S_FAULT:     w_next = S_FAULT;
      default:     w_next = S_IDLE;
    endcase
  end

  always_comb begin
    fetch_req   = 1'b0;
    ir_load     = 1'b0;
    reg_read_en = 1'b0;
    alu_en      = 1'b0;
    mem_req     = 1'b0;
    wb_en       = 1'b0;
    pc_update   = 1'b0;
    fault       = 1'b0;
    case (r_state)
      S_FETCH: begin
        fetch_req = 1'b1;
        ir_load   = fetch_ack;
      end
      S_DECODE:    reg_read_en = 1'b1;
      S_EXECUTE:   alu_en      = 1'b1;
      S_MEMORY:    mem_req     = 1'b1;
      S_WRITEBACK: begin
        pc_update = 1'b1;
        wb_en     = r_reg_write;
      end
      S_FAULT:     fault = 1'b1;
      default: ;
    endcase
    busy = (r_state != S_IDLE) && (r_state != S_FAULT);
  end

  assign state   = r_state;
  assign retired = r_retired;

endmodule

// File: tb/tb_instr_sequencer.sv
// Scoreboard bench for instr_sequencer: per-instruction expectations are queued at issue
// and checked when the DUT retires the instruction (pc_update).
module tb_instr_sequencer;

  localparam int TMO = 4;
  localparam int CW  = 4;

  logic          clk = 1'b0;
  logic          reset, run, fetch_ack, mem_read, mem_write, reg_write, mem_ack;
`ifdef INSTR_SEQUENCER_SINGLE_STEP_EN
  logic          step;
`endif
  logic          fetch_req, ir_load, reg_read_en, alu_en, mem_req, wb_en, pc_update, busy, fault;
  logic [2:0]    state;
  logic [CW-1:0] retired;

  instr_sequencer #(.MEM_TIMEOUT(TMO), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .run(run),
`ifdef INSTR_SEQUENCER_SINGLE_STEP_EN
    .step(step),
`endif
    .fetch_ack(fetch_ack), .mem_read(mem_read), .mem_write(mem_write),
    .reg_write(reg_write), .mem_ack(mem_ack),
    .fetch_req(fetch_req), .ir_load(ir_load), .reg_read_en(reg_read_en), .alu_en(alu_en),
    .mem_req(mem_req), .wb_en(wb_en), .pc_update(pc_update), .busy(busy), .fault(fault),
    .state(state), .retired(retired)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          rw;
    int            mem_cycles;
    logic [CW-1:0] ret;
  } exp_t;

  exp_t          sb_q[$];
  int            n_tests = 0;
  int            n_fail  = 0;
  logic [CW-1:0] exp_ret = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Output monitor, sampled on the falling edge.
  int            m_mem, m_ir, m_rr, m_alu;
  logic          m_ret_pend = 1'b0;
  logic [CW-1:0] m_ret_exp;

  always @(negedge clk) begin
    if (reset) begin
      m_mem = 0; m_ir = 0; m_rr = 0; m_alu = 0; m_ret_pend = 1'b0;
    end else begin
      if (m_ret_pend) begin
        check("sb_retired", retired, m_ret_exp);
        m_ret_pend = 1'b0;
      end
      if ($countones({reg_read_en, alu_en, mem_req, wb_en}) > 1)
        check("stage_exclusive", {reg_read_en, alu_en, mem_req, wb_en}, 4'b0000);
      if (mem_req)     m_mem++;
      if (ir_load)     m_ir++;
      if (reg_read_en) m_rr++;
      if (alu_en)      m_alu++;
      if (pc_update) begin
        if (sb_q.size() == 0) begin
          check("sb_unexpected_retire", sb_q.size(), 1);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          check("sb_wb_en", wb_en, e.rw);
          check("sb_mem_cycles", m_mem, e.mem_cycles);
          check("sb_ir_load_pulses", m_ir, 1);
          check("sb_reg_read_pulses", m_rr, 1);
          check("sb_alu_pulses", m_alu, 1);
          m_ret_exp  = e.ret;
          m_ret_pend = 1'b1;
        end
        m_mem = 0; m_ir = 0; m_rr = 0; m_alu = 0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic mr, input logic mw, input logic rw, input int ack_on);
    exp_t e;
    e.rw         = rw;
    e.mem_cycles = (mr | mw) ? ack_on : 0;
    exp_ret      = exp_ret + 1'b1;
    e.ret        = exp_ret;
    sb_q.push_back(e);
  endtask

  // Runs one instruction until WRITEBACK is observed; mem_ack on MEMORY cycle ack_on,
  // fetch_ack after fetch_wait stalled FETCH cycles, optionally drop run in EXECUTE.
  task automatic do_instr(input logic mr, input logic mw, input logic rw, input int ack_on,
                          input int fetch_wait, input logic drop_run);
    int mcnt = 0;
    int fcnt = 0;
    bit done = 0;
    mem_read = mr; mem_write = mw; reg_write = rw;
    push_exp(mr, mw, rw, ack_on);
    for (int cyc = 0; cyc < 60 && !done; cyc++) begin
      tick();
      if (state == 3'd1) fcnt++;
      if (state == 3'd4) mcnt++;
      fetch_ack = (state != 3'd1) || (fcnt > fetch_wait);
      mem_ack   = (state != 3'd4) || (mcnt == ack_on);
      if (state == 3'd3) begin
        mem_read = ~mr; mem_write = ~mw; reg_write = ~rw;
        if (drop_run) run = 1'b0;
      end
      if (state == 3'd5) done = 1;
    end
    if (!done) check("instr_reach_wb", state, 3'd5);
    mem_ack = 1'b0; fetch_ack = 1'b1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    exp_ret = '0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int seq5[5] = '{1, 2, 3, 5, 1};
    int p_ir, p_rr, p_alu, p_wb, p_pc, mcnt;

    reset = 1'b1; run = 1'b0; fetch_ack = 1'b1; mem_ack = 1'b0;
    mem_read = 1'b0; mem_write = 1'b0; reg_write = 1'b0;
`ifdef INSTR_SEQUENCER_SINGLE_STEP_EN
    step = 1'b0;
`endif
    do_reset();
    check("reset_state", state, 3'd0);
    check("reset_outputs", {fetch_req, ir_load, reg_read_en, alu_en, mem_req, wb_en,
                            pc_update, busy, fault}, 9'd0);
    check("reset_retired", retired, 0);

    // ALU instruction, exact state sequence and single pulses.
    reg_write = 1'b1;
    push_exp(1'b0, 1'b0, 1'b1, 0);
    run = 1'b1;
    p_ir = 0; p_rr = 0; p_alu = 0; p_wb = 0; p_pc = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check($sformatf("alu_seq[%0d]", i), state, seq5[i]);
      if (i < 4) begin
        p_ir += ir_load; p_rr += reg_read_en; p_alu += alu_en; p_wb += wb_en; p_pc += pc_update;
      end
    end
    check("alu_pulses", {p_ir[3:0], p_rr[3:0], p_alu[3:0], p_wb[3:0], p_pc[3:0]}, 20'h11111);
    check("alu_retired", retired, 1);

    // Load with ack on 3rd MEMORY cycle, store, fetch stall, ack on the timeout cycle.
    do_instr(1'b1, 1'b0, 1'b1, 3, 0, 1'b0);
    do_instr(1'b0, 1'b1, 1'b0, 1, 0, 1'b0);
    do_instr(1'b0, 1'b0, 1'b1, 0, 2, 1'b0);
    do_instr(1'b1, 1'b0, 1'b1, TMO, 0, 1'b0);

    // run dropped in EXECUTE: instruction finishes, then IDLE with no fetch.
    do_instr(1'b0, 1'b0, 1'b0, 0, 0, 1'b1);
    tick();
    check("drop_run_idle", state, 3'd0);
    check("drop_run_retired", retired, exp_ret);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("drop_run_no_fetch", {fetch_req, busy, state}, 5'd0);
    end

    // Memory timeout: no mem_ack ever.
    mem_read = 1'b1; mem_write = 1'b0; reg_write = 1'b1; mem_ack = 1'b0;
    run = 1'b1; mcnt = 0;
    for (int i = 0; i < 40 && state != 3'd6; i++) begin
      tick();
      if (mem_req) mcnt++;
    end
    check("tmo_mem_cycles", mcnt, TMO);
    check("tmo_state", state, 3'd6);
    check("tmo_flags", {fault, busy}, 2'b10);
    check("tmo_retired", retired, exp_ret);
    mem_ack = 1'b1;
    repeat (5) tick();
    check("fault_sticky", {state, fault}, {3'd6, 1'b1});
    check("fault_retired", retired, exp_ret);
    mem_ack = 1'b0; run = 1'b0;
    do_reset();
    check("fault_reset", {state, fault, retired}, 8'd0);

    // Reset while in MEMORY.
    run = 1'b1;
    do_instr(1'b0, 1'b0, 1'b1, 0, 0, 1'b0);
    do_instr(1'b0, 1'b1, 1'b0, 2, 1, 1'b0);
    mem_read = 1'b1; mem_write = 1'b0; reg_write = 1'b1;
    for (int i = 0; i < 20 && state != 3'd4; i++) tick();
    check("mem_reset_pre", {state, mem_req}, {3'd4, 1'b1});
    run = 1'b0;
    do_reset();
    check("mem_reset_post", {state, mem_req, busy, retired}, 9'd0);

    // Counter wrap with CNT_W=4 across 16 mixed instructions.
    run = 1'b1;
    for (int i = 0; i < 16; i++) begin
      logic mr, mw;
      mr = 1'($urandom_range(0, 1));
      mw = 1'($urandom_range(0, 1));
      do_instr(mr, mw, 1'($urandom_range(0, 1)), $urandom_range(1, 3), $urandom_range(0, 1), 1'b0);
    end
    run = 1'b0;
    tick();
    check("wrap_retired", retired, 0);
    check("wrap_idle", state, 3'd0);

`ifdef INSTR_SEQUENCER_SINGLE_STEP_EN
    begin
      int st1[6]  = '{2, 3, 5, 0, 0, 0};
      int st2[10] = '{1, 2, 3, 5, 0, 1, 2, 3, 5, 0};
      mem_read = 1'b0; mem_write = 1'b0; reg_write = 1'b1;
      push_exp(1'b0, 1'b0, 1'b1, 0);
      step = 1'b1;
      tick();
      check("step_start", state, 3'd1);
      step = 1'b0;
      for (int i = 0; i < 6; i++) begin
        tick();
        check($sformatf("step_seq[%0d]", i), state, st1[i]);
      end
      check("step_retired", retired, exp_ret);
      push_exp(1'b0, 1'b0, 1'b1, 0);
      push_exp(1'b0, 1'b0, 1'b1, 0);
      step = 1'b1;
      for (int i = 0; i < 10; i++) begin
        tick();
        check($sformatf("step_hold_seq[%0d]", i), state, st2[i]);
      end
      step = 1'b0;
      tick();
      check("step_hold_end", {state, retired}, {3'd0, exp_ret});
    end
`endif

    repeat (2) tick();
    check("sb_drained", sb_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/instr_sequencer.md
Name: instr_sequencer

Overview:
Multi-cycle control sequencer for the non-pipelined LEGv8 core. It steps each instruction through FETCH, DECODE, EXECUTE, MEMORY and WRITEBACK, and generates the stage enables for the instruction register, the register-file read/write strobes, the ALU, data memory and the PC. It takes the decoded control flags (mem_read, mem_write, reg_write) from the decode stage. It also handles the memory handshakes, a data-memory timeout, and a retired-instruction counter.

Parameters:
MEM_TIMEOUT, 255, max MEMORY-state cycles without mem_ack before fault; 0 disables timeout
CNT_W, 32, width of retired counter

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  synchronous, active-high
run  input  1  level; sequencer fetches new instructions while high
fetch_ack  input  1  instruction memory has valid instruction this cycle
mem_read  input  1  decoded load flag, sampled in DECODE
mem_write  input  1  decoded store flag, sampled in DECODE
reg_write  input  1  decoded register-write flag, sampled in DECODE
mem_ack  input  1  data memory completed access this cycle
fetch_req  output  1  instruction fetch request
ir_load  output  1  instruction register load strobe
reg_read_en  output  1  register-file read strobe
alu_en  output  1  execute-stage enable
mem_req  output  1  data memory request
wb_en  output  1  register-file write strobe
pc_update  output  1  PC advance strobe
busy  output  1  high in any state except IDLE and FAULT
fault  output  1  sticky memory-timeout flag
state  output  3  current state encoding
retired  output  CNT_W  count of completed instructions

Behaviour:
- States and encoding: IDLE=0, FETCH=1, DECODE=2, EXECUTE=3, MEMORY=4, WRITEBACK=5, FAULT=6. Code 7 is unreachable; if entered, go to IDLE.
- Reset (synchronous, wins over everything): state=IDLE, retired=0, timeout counter=0, latched flags=0, fault=0. All outputs are 0 in the cycle after reset.
- Output decode:
  - Moore from state: fetch_req=(FETCH), reg_read_en=(DECODE), alu_en=(EXECUTE), mem_req=(MEMORY), pc_update=(WRITEBACK), fault=(FAULT), busy as defined above.
  - ir_load=(FETCH && fetch_ack), combinational.
  - wb_en=(WRITEBACK && latched reg_write).
- IDLE: run=1 -> FETCH, else stay.
- FETCH: stay until fetch_ack=1, then -> DECODE. There is no fetch timeout.
- DECODE: latch mem_read, mem_write and reg_write at the clock edge leaving DECODE; always -> EXECUTE.
- EXECUTE: latched (mem_read|mem_write) -> MEMORY, else -> WRITEBACK.
- MEMORY:
  - Timeout counter is cleared on entry.
  - mem_ack=1 -> WRITEBACK.
  - Otherwise the counter increments. If MEM_TIMEOUT!=0 and the counter reaches MEM_TIMEOUT-1 without mem_ack (i.e. mem_req held MEM_TIMEOUT cycles unacknowledged), go to FAULT.
  - If mem_ack arrives in the same cycle as the timeout, mem_ack wins.
- WRITEBACK: retired increments by 1, wrapping at 2^CNT_W to 0. Then run=1 -> FETCH, else -> IDLE.
- FAULT: absorbing. Only reset exits. retired does not increment.
- run deasserted mid-instruction: the current instruction completes through WRITEBACK, then the sequencer goes to IDLE.
- Latency: minimum 4 cycles per instruction without memory access (FETCH with same-cycle ack, DECODE, EXECUTE, WRITEBACK). With memory access: 5 cycles plus mem_ack wait cycles.
- Input flags are ignored outside DECODE. mem_ack outside MEMORY and fetch_ack outside FETCH are ignored.
- At most one of reg_read_en, alu_en, mem_req, wb_en is high in any cycle.

Optional Feature:
INSTR_SEQUENCER_SINGLE_STEP_EN.
- Defined: adds input port step (1 bit). In IDLE, step=1 with run=0 starts exactly one instruction; after its WRITEBACK the sequencer returns to IDLE regardless of step. If run=1, step is ignored. step held high re-triggers only after IDLE is re-entered.
- Undefined: the step port does not exist and only run starts fetches.

Test Plan:
1. Reset, run=1, fetch_ack=1 always, ALU instruction (reg_write=1, mem flags 0) -> state sequence 0,1,2,3,5,1. Exactly one ir_load, reg_read_en, alu_en, wb_en and pc_update pulse, each one cycle. retired goes 0->1.
2. Load (mem_read=1, reg_write=1), mem_ack asserted on the 3rd MEMORY cycle -> mem_req high for exactly 3 cycles, then WRITEBACK with wb_en=1. Store (mem_write=1, reg_write=0) -> wb_en stays 0 while pc_update pulses.
3. MEM_TIMEOUT=4, load, mem_ack never asserted -> mem_req high 4 cycles, then state=6, fault=1, busy=0, retired unchanged. FAULT holds until reset; reset returns state 0 and fault 0.
4. run dropped during EXECUTE -> instruction completes, retired increments, state becomes 0, fetch_req stays 0 afterwards.
5. reset asserted during MEMORY with mem_req=1 -> next cycle state=0, mem_req=0, retired=0. CNT_W=4 with 16 instructions retired -> retired wraps 15->0.
6. With INSTR_SEQUENCER_SINGLE_STEP_EN defined, run=0, one-cycle step pulse -> exactly one instruction retires and the sequencer returns to state 0. With step held high, retired increments once per IDLE re-entry.
